adder_launch_capture: RTL

//  Launch/capture harness for the 8-bit combinational adder under test. Registers operands (fixed
//  or LFSR) onto the adder inputs and samples the adder sum a programmable number of clocks later.

---
 rtl/adder_test_pkg.sv | 23 ++
 rtl/adder_lfsr.sv | 23 ++
 rtl/adder_launch_capture.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/adder_test_pkg.sv
// Shared constants for the adder launch/capture harness: FSM encodings and LFSR definition.
package adder_test_pkg;

    localparam int unsigned LFSR_W  = 16;
    localparam int unsigned STATE_W = 3;

    localparam logic [STATE_W-1:0] ST_IDLE    = 3'd0;
    localparam logic [STATE_W-1:0] ST_LAUNCH  = 3'd1;
    localparam logic [STATE_W-1:0] ST_SETTLE  = 3'd2;
    localparam logic [STATE_W-1:0] ST_CAPTURE = 3'd3;
    localparam logic [STATE_W-1:0] ST_CHECK   = 3'd4;
    localparam logic [STATE_W-1:0] ST_DONE    = 3'd5;

    localparam logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1;
    // Feedback taps of x^16+x^14+x^13+x^11+1 in right-shifting Fibonacci form
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'h002D;

    // One Fibonacci step: feedback bit enters at the MSB
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
        return {^(s & LFSR_TAPS), s[LFSR_W-1:1]};
    endfunction

endpackage

// File: rtl/adder_lfsr.sv
// 16-bit Fibonacci LFSR operand source with synchronous reseed and advance controls.
module adder_lfsr
    import adder_test_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load_seed,
    input  logic              advance,
    output logic [LFSR_W-1:0] value
);

    // Reseed takes priority; reseed together with advance yields the seed's successor
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value <= LFSR_SEED;
        end else if (load_seed) begin
            value <= advance ? lfsr_next(LFSR_SEED) : LFSR_SEED;
        end else if (advance) begin
            value <= lfsr_next(value);
        end
    end

endmodule

// File: rtl/adder_launch_capture.sv
// Launch/capture harness: drives registered operands into the adder, samples its sum after a
// programmable settle time and keeps saturating pass/fail statistics.
module adder_launch_capture
    import adder_test_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned SETTLE_W = 4,
    parameter int unsigned COUNT_W  = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [COUNT_W-1:0]  run_count,
    input  logic                use_lfsr,
    input  logic [WIDTH-1:0]    a_fixed,
    input  logic [WIDTH-1:0]    b_fixed,
    input  logic [SETTLE_W-1:0] settle_cycles,
    output logic [WIDTH-1:0]    a_to_adder,
    output logic [WIDTH-1:0]    b_to_adder,
    input  logic [WIDTH-1:0]    sum_from_adder,
    output logic                busy,
    output logic                done,
    output logic [COUNT_W-1:0]  pass_count,
    output logic [COUNT_W-1:0]  fail_count,
    output logic [WIDTH-1:0]    last_fail_sum
);

    // The LFSR supplies both operands, so it must be exactly twice the operand width
    if (WIDTH != 8) begin : g_bad_width
        $error("adder_launch_capture: only WIDTH=8 is supported");
    end

    logic [STATE_W-1:0]  state, state_nxt;
    logic [COUNT_W-1:0]  run_q;
    logic                use_lfsr_q;
    logic [WIDTH-1:0]    a_fix_q, b_fix_q;
    logic [SETTLE_W-1:0] settle_q, settle_left;
    logic [COUNT_W-1:0]  vec_cnt;
    logic [WIDTH-1:0]    cap_sum, cap_exp;
    logic [LFSR_W-1:0]   lfsr_val;

    logic                start_ok_c, more_c, load_ops_c, lfsr_mode_c, match_c;
    logic [COUNT_W:0]    vec_inc_c;
    logic [WIDTH-1:0]    a_src_c, b_src_c;

    assign start_ok_c  = (state == ST_IDLE) && start;
    assign vec_inc_c   = {1'b0, vec_cnt} + (COUNT_W+1)'(1);
    assign more_c      = vec_inc_c < {1'b0, run_q};
    // Operands load on every entry into LAUNCH, so the settle window starts with the launch cycle
    assign load_ops_c  = (start_ok_c && (run_count != '0)) || ((state == ST_CHECK) && more_c);
    assign lfsr_mode_c = start_ok_c ? use_lfsr : use_lfsr_q;
    assign match_c     = (cap_sum == cap_exp);

    // Operand source: live config on the accepting edge, latched config afterwards
    always_comb begin
        a_src_c = a_fix_q;
        b_src_c = b_fix_q;
        if (start_ok_c) begin
            a_src_c = use_lfsr ? LFSR_SEED[2*WIDTH-1:WIDTH] : a_fixed;
            b_src_c = use_lfsr ? LFSR_SEED[WIDTH-1:0]       : b_fixed;
        end else if (use_lfsr_q) begin
            a_src_c = lfsr_val[2*WIDTH-1:WIDTH];
            b_src_c = lfsr_val[WIDTH-1:0];
        end
    end

    adder_lfsr u_lfsr (
        .clk       (clk),
        .reset     (reset),
        .load_seed (start_ok_c),
        .advance   (load_ops_c && lfsr_mode_c),
        .value     (lfsr_val)
    );

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (start) state_nxt = (run_count == '0) ? ST_DONE : ST_LAUNCH;
            ST_LAUNCH:  state_nxt = (settle_q == '0) ? ST_CAPTURE : ST_SETTLE;
            ST_SETTLE:  if (settle_left == SETTLE_W'(1)) state_nxt = ST_CAPTURE;
            ST_CAPTURE: state_nxt = ST_CHECK;
            ST_CHECK:   state_nxt = more_c ? ST_LAUNCH : ST_DONE;
            ST_DONE:    state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    // State register with registered status flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt != ST_IDLE);
            done  <= (state_nxt == ST_DONE);
        end
    end

    // Run configuration, captured only when a start is accepted
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            run_q      <= '0;
            use_lfsr_q <= 1'b0;
            a_fix_q    <= '0;
            b_fix_q    <= '0;
            settle_q   <= '0;
        end else if (start_ok_c) begin
            run_q      <= run_count;
            use_lfsr_q <= use_lfsr;
            a_fix_q    <= a_fixed;
            b_fix_q    <= b_fixed;
            settle_q   <= settle_cycles;
        end
    end

    // Operand launch registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_to_adder <= '0;
            b_to_adder <= '0;
        end else if (load_ops_c) begin
            a_to_adder <= a_src_c;
            b_to_adder <= b_src_c;
        end
    end

    // Settle countdown, reloaded in every LAUNCH cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            settle_left <= '0;
        end else if (state == ST_LAUNCH) begin
            settle_left <= settle_q;
        end else if (state == ST_SETTLE) begin
            settle_left <= settle_left - SETTLE_W'(1);
        end
    end

    // Capture of the adder result and the reference sum (carry out dropped)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cap_sum <= '0;
            cap_exp <= '0;
        end else if (state == ST_CAPTURE) begin
            cap_sum <= sum_from_adder;
            cap_exp <= a_to_adder + b_to_adder;
        end
    end

    // Result bookkeeping: cleared on accepted start, updated once per vector in CHECK
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pass_count    <= '0;
            fail_count    <= '0;
            last_fail_sum <= '0;
            vec_cnt       <= '0;
        end else if (start_ok_c) begin
            pass_count    <= '0;
            fail_count    <= '0;
            last_fail_sum <= '0;
            vec_cnt       <= '0;
        end else if (state == ST_CHECK) begin
            vec_cnt <= vec_inc_c[COUNT_W-1:0];
            if (match_c) begin
                if (pass_count != '1) pass_count <= pass_count + COUNT_W'(1);
            end else begin
                if (fail_count != '1) fail_count <= fail_count + COUNT_W'(1);
                last_fail_sum <= cap_sum;
            end
        end
    end

endmodule
